mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one external single-ported, variable-latency memory between the pipeline's instruction-fetch (IF) and data-memory (MEM) stages. Each access is a latched transaction with a req/ack handshake toward memory, and each requester gets a one-cycle ready pulse back. The arbiter generates per-stage stall signals that feed the PC and pipeline-register hold logic. An ack watchdog flags hung transactions.

Parameters:
ACK_TIMEOUT, 255, max cycles waiting for ext_ack_i before abort; 0 disables the watchdog
MAX_MEM_BURST, 4, consecutive MEM grants allowed while IF waits (only with ARB_FAIR_EN)
ABORT_DATA, 32'hDEADBEEF, read data returned on an aborted transaction

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  reset, asynchronous, active-low
if_req_i  in  1  IF read request; held high until if_ready_o
if_addr_i  in  32  IF word address
if_data_o  out  32  fetched instruction; valid on if_ready_o, held until next IF completion
if_ready_o  out  1  one-cycle completion pulse
if_stall_o  out  1  if_req_i & ~if_ready_o (combinational)
mem_req_i  in  1  MEM request; held high until mem_ready_o
mem_we_i  in  1  1=write, 0=read
mem_addr_i  in  32  data address
mem_wdata_i  in  32  write data
mem_rdata_o  out  32  read data; valid on mem_ready_o, held until next MEM completion
mem_ready_o  out  1  one-cycle completion pulse
mem_stall_o  out  1  mem_req_i & ~mem_ready_o (combinational)
ext_req_o  out  1  memory request, registered
ext_we_o  out  1  memory write enable, registered
ext_addr_o  out  32  memory address, registered
ext_wdata_o  out  32  memory write data, registered
ext_rdata_i  in  32  memory read data, sampled on ext_ack_i
ext_ack_i  in  1  memory completion, one cycle
err_o  out  1  sticky timeout flag

Behaviour:
- Reset (async, rst_n_i=0): state=IDLE. All outputs 0, including data holds and err_o. Wait and fairness counters cleared. A reset mid-transaction drops ext_req_o immediately, with no completion pulse.
- States: IDLE, GNT_IF, GNT_MEM, RESP.
- IDLE: mem_req_i wins, then GNT_MEM; otherwise if_req_i wins, then GNT_IF.
  - At the grant edge, latch addr/we/wdata into the ext_* registers and set ext_req_o=1. IF grants force ext_we_o=0.
- GNT_x: ext_* are held stable.
  - On the ext_ack_i cycle: capture ext_rdata_i into the x data register (reads only; writes leave the register unchanged), clear ext_req_o, go to RESP.
- RESP: exactly one cycle. The finished requester's ready_o=1. A new grant is never given to the requester being completed.
  - If the other requester is pending, grant it directly from RESP (same latching rules). Otherwise go to IDLE.
- Minimum latency: request seen at edge N → ext_req_o high from N+1. With ack at cycle N+1, ready_o is high in cycle N+2.
- Watchdog (ACK_TIMEOUT>0): counter counts cycles in GNT_x and clears on grant.
  - If it reaches ACK_TIMEOUT without ack: drop ext_req_o, load ABORT_DATA (reads), set err_o=1, go to RESP, and complete normally.
  - An ext_ack_i arriving in the same cycle as the timeout wins; no error is raised.
- ext_ack_i in IDLE or RESP is ignored.
- Arbitration is never preemptive: a granted transaction always completes or times out.
- Strict MEM priority, because the older instruction must retire first.

Optional Feature:
ARB_FAIR_EN
- Defined: a 3-bit+ counter increments on each MEM grant made while if_req_i is pending, and clears on any IF grant. When it reaches MAX_MEM_BURST, the next grant goes to IF even if MEM is pending.
- Undefined: strict MEM priority; no counter logic is instantiated.

Test Plan:
- Reset: rst_n_i=0 mid-GNT_MEM → ext_req_o=0 and all ready/err=0 asynchronously; after release, state=IDLE and no ready pulse.
- Single IF read: if_req_i=1, addr=0x40, memory acks 1 cycle later with 0x8C220004 → if_ready_o pulses once, if_data_o=0x8C220004, if_stall_o=1 until the pulse, ext_we_o=0 throughout.
- Simultaneous requests: if_req_i=1 and mem_req_i=1 write 0x12345678 to 0x100 in the same cycle → MEM granted first (ext_we_o=1, ext_wdata_o=0x12345678). IF granted straight from RESP, and no duplicate MEM grant occurs.
- Variable latency: ack delayed 7 cycles → ext_addr_o stable all 7 cycles and mem_ready_o pulses exactly once.
- Timeout: ACK_TIMEOUT=8, ack never arrives → ext_req_o drops after 8 cycles, mem_rdata_o=0xDEADBEEF, err_o=1 and stays set. The next transaction completes normally.
- With ARB_FAIR_EN and MAX_MEM_BURST=4: mem_req_i and if_req_i held high continuously → grant order is MEM×4, then IF, then MEM×4.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Handshake and bus bundle for mem_port_arbiter.
// Groups the IF requester, MEM requester and external memory signals.
//   master : arbiter view (drives ready/data/stall, ext_* command, err_o)
//   slave  : environment view (pipeline stages + external memory)
interface mem_port_arbiter_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  // Instruction-fetch requester
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_data_o;
  logic              if_ready_o;
  logic              if_stall_o;

  // Data-memory requester
  logic              mem_req_i;
  logic              mem_we_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic [DATA_W-1:0] mem_rdata_o;
  logic              mem_ready_o;
  logic              mem_stall_o;

  // External memory port
  logic              ext_req_o;
  logic              ext_we_o;
  logic [ADDR_W-1:0] ext_addr_o;
  logic [DATA_W-1:0] ext_wdata_o;
  logic [DATA_W-1:0] ext_rdata_i;
  logic              ext_ack_i;

  // Sticky watchdog flag
  logic              err_o;

  modport master (
    input  if_req_i, if_addr_i,
    output if_data_o, if_ready_o, if_stall_o,
    input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
    output mem_rdata_o, mem_ready_o, mem_stall_o,
    output ext_req_o, ext_we_o, ext_addr_o, ext_wdata_o,
    input  ext_rdata_i, ext_ack_i,
    output err_o
  );

  modport slave (
    output if_req_i, if_addr_i,
    input  if_data_o, if_ready_o, if_stall_o,
    output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
    input  mem_rdata_o, mem_ready_o, mem_stall_o,
    input  ext_req_o, ext_we_o, ext_addr_o, ext_wdata_o,
    output ext_rdata_i, ext_ack_i,
    input  err_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between the IF and MEM
// pipeline stages. One latched transaction at a time, req/ack toward memory,
// one-cycle ready pulse back to the requester, combinational stalls, and an
// ack watchdog that aborts hung transactions and raises a sticky err_o.
//
// Ports:
//   clk_i    rising-edge clock
//   rst_n_i  asynchronous active-low reset
//   bus      mem_port_arbiter_if.master (IF/MEM requesters, ext memory, err_o)
//
// Parameters:
//   ACK_TIMEOUT    cycles waiting for ext_ack_i before abort (0 = no watchdog)
//   MAX_MEM_BURST  MEM grants allowed while IF waits (fair mode only)
//   ABORT_DATA     read data returned by an aborted transaction
//
// Build option:
//   ARB_FAIR_EN    when defined, IF is forced in after MAX_MEM_BURST MEM grants
//                  made while IF was waiting; otherwise strict MEM priority.
module mem_port_arbiter #(
  parameter int unsigned ACK_TIMEOUT   = 255,
  parameter int unsigned MAX_MEM_BURST = 4,
  parameter logic [31:0] ABORT_DATA    = 32'hDEADBEEF
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  mem_port_arbiter_if.master bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WD_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    GNT_IF,
    GNT_MEM,
    RESP
  } state_e;

  // Command latched toward external memory at grant time
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ext_cmd_t;

  state_e            state_q;
  logic              resp_mem_q;
  ext_cmd_t          ext_cmd_q;
  logic              ext_req_q;
  logic [WD_W-1:0]   wd_cnt_q;
  logic              if_ready_q;
  logic              mem_ready_q;
  logic [DATA_W-1:0] if_data_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic              err_q;

  logic              grant_if_c;
  logic              grant_mem_c;
  logic              wd_expire_c;
  logic              burst_spent_c;
  logic [DATA_W-1:0] rsp_data_c;

`ifdef ARB_FAIR_EN
  localparam bit          FAIR_EN = 1'b1;
  localparam int unsigned FC_W    = ($clog2(MAX_MEM_BURST + 1) > 3) ?
                                    $clog2(MAX_MEM_BURST + 1) : 3;

  logic [FC_W-1:0] fair_cnt_q;

  assign burst_spent_c = (fair_cnt_q >= FC_W'(MAX_MEM_BURST));

  // MEM grants taken while IF waits; cleared whenever IF gets the port
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fair_cnt_q <= '0;
    end else if (grant_if_c) begin
      fair_cnt_q <= '0;
    end else if (grant_mem_c && bus.if_req_i && !burst_spent_c) begin
      fair_cnt_q <= fair_cnt_q + FC_W'(1);
    end
  end
`else
  localparam bit FAIR_EN = 1'b0;

  assign burst_spent_c = 1'b0;
`endif

  // Abort on the last allowed wait cycle; an ack in that cycle takes precedence
  assign wd_expire_c = (ACK_TIMEOUT != 0) &&
                       (wd_cnt_q == WD_W'(ACK_TIMEOUT - 1));

  assign rsp_data_c = bus.ext_ack_i ? bus.ext_rdata_i : ABORT_DATA;

  // Grant decision. Only IDLE and RESP may grant; RESP never regrants the
  // requester it is completing, whose req is still high this cycle.
  always_comb begin
    grant_if_c  = 1'b0;
    grant_mem_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.if_req_i && burst_spent_c) begin
          grant_if_c = 1'b1;
        end else if (bus.mem_req_i) begin
          grant_mem_c = 1'b1;
        end else if (bus.if_req_i) begin
          grant_if_c = 1'b1;
        end
      end
      RESP: begin
        // In fair mode a MEM completion returns to IDLE so MEM keeps priority
        // until its burst budget is spent.
        if (resp_mem_q) begin
          if (bus.if_req_i && (burst_spent_c || !FAIR_EN)) begin
            grant_if_c = 1'b1;
          end
        end else if (bus.mem_req_i) begin
          grant_mem_c = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Transaction FSM with registered ext_*, ready, data holds and error flag
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      resp_mem_q  <= 1'b0;
      ext_cmd_q   <= '0;
      ext_req_q   <= 1'b0;
      wd_cnt_q    <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if (grant_mem_c) begin
        state_q         <= GNT_MEM;
        ext_req_q       <= 1'b1;
        ext_cmd_q.we    <= bus.mem_we_i;
        ext_cmd_q.addr  <= bus.mem_addr_i;
        ext_cmd_q.wdata <= bus.mem_wdata_i;
        wd_cnt_q        <= '0;
      end else if (grant_if_c) begin
        state_q        <= GNT_IF;
        ext_req_q      <= 1'b1;
        ext_cmd_q.we   <= 1'b0;
        ext_cmd_q.addr <= bus.if_addr_i;
        wd_cnt_q       <= '0;
      end else begin
        unique case (state_q)
          GNT_IF, GNT_MEM: begin
            if (bus.ext_ack_i || wd_expire_c) begin
              ext_req_q  <= 1'b0;
              state_q    <= RESP;
              resp_mem_q <= (state_q == GNT_MEM);
              if (!bus.ext_ack_i) begin
                err_q <= 1'b1;
              end
              if (state_q == GNT_MEM) begin
                mem_ready_q <= 1'b1;
                if (!ext_cmd_q.we) begin
                  mem_rdata_q <= rsp_data_c;
                end
              end else begin
                if_ready_q <= 1'b1;
                if_data_q  <= rsp_data_c;
              end
            end else begin
              wd_cnt_q <= wd_cnt_q + WD_W'(1);
            end
          end
          RESP: begin
            state_q <= IDLE;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.ext_req_o   = ext_req_q;
  assign bus.ext_we_o    = ext_cmd_q.we;
  assign bus.ext_addr_o  = ext_cmd_q.addr;
  assign bus.ext_wdata_o = ext_cmd_q.wdata;
  assign bus.if_data_o   = if_data_q;
  assign bus.if_ready_o  = if_ready_q;
  assign bus.mem_rdata_o = mem_rdata_q;
  assign bus.mem_ready_o = mem_ready_q;
  assign bus.err_o       = err_q;

  // Stalls follow the request combinationally and release on the ready pulse
  assign bus.if_stall_o  = bus.if_req_i  & ~if_ready_q;
  assign bus.mem_stall_o = bus.mem_req_i & ~mem_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (ACK_TIMEOUT=8, MAX_MEM_BURST=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_port_arbiter;

  logic clk_i = 1'b0;
  logic rst_n_i;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(
    .ACK_TIMEOUT  (8),
    .MAX_MEM_BURST(4),
    .ABORT_DATA   (32'hDEADBEEF)
  ) dut (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_if_data;
  int          pulses;
  int          n_grants;
  logic        prev_req;
  logic        grant_we [10];
  logic        exp_we   [10];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = '0;
    bus.mem_req_i   = 1'b0;
    bus.mem_we_i    = 1'b0;
    bus.mem_addr_i  = '0;
    bus.mem_wdata_i = '0;
    bus.ext_rdata_i = '0;
    bus.ext_ack_i   = 1'b0;
  endtask

  initial begin
    rst_n_i = 1'b0;
    idle_inputs();
    step();
    step();

    // Reset values
    check("rst_ext_req",   32'(bus.ext_req_o),   32'd0);
    check("rst_if_ready",  32'(bus.if_ready_o),  32'd0);
    check("rst_mem_ready", 32'(bus.mem_ready_o), 32'd0);
    check("rst_err",       32'(bus.err_o),       32'd0);
    check("rst_if_data",   bus.if_data_o,        32'd0);
    check("rst_mem_rdata", bus.mem_rdata_o,      32'd0);
    rst_n_i = 1'b1;
    step();

    // Single IF read, ack one cycle after grant
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h40;
    #1;
    check("if1_stall_req", 32'(bus.if_stall_o), 32'd1);
    step();
    check("if1_ext_req",  32'(bus.ext_req_o),  32'd1);
    check("if1_ext_we",   32'(bus.ext_we_o),   32'd0);
    check("if1_ext_addr", bus.ext_addr_o,      32'h40);
    check("if1_ready_lo", 32'(bus.if_ready_o), 32'd0);
    check("if1_stall_hi", 32'(bus.if_stall_o), 32'd1);
    bus.ext_ack_i   = 1'b1;
    bus.ext_rdata_i = 32'h8C220004;
    step();
    check("if1_ready",    32'(bus.if_ready_o), 32'd1);
    check("if1_data",     bus.if_data_o,       32'h8C220004);
    check("if1_stall_lo", 32'(bus.if_stall_o), 32'd0);
    check("if1_req_drop", 32'(bus.ext_req_o),  32'd0);
    check("if1_we_resp",  32'(bus.ext_we_o),   32'd0);
    exp_if_data   = 32'h8C220004;
    bus.ext_ack_i = 1'b0;
    bus.if_req_i  = 1'b0;
    step();
    check("if1_one_pulse", 32'(bus.if_ready_o), 32'd0);
    check("if1_data_hold", bus.if_data_o,       exp_if_data);

`ifndef ARB_FAIR_EN
    // Simultaneous requests: MEM write first, IF straight from RESP
    bus.if_req_i    = 1'b1;
    bus.if_addr_i   = 32'h44;
    bus.mem_req_i   = 1'b1;
    bus.mem_we_i    = 1'b1;
    bus.mem_addr_i  = 32'h100;
    bus.mem_wdata_i = 32'h12345678;
    step();
    check("sim_mem_first", 32'(bus.ext_we_o),    32'd1);
    check("sim_mem_addr",  bus.ext_addr_o,       32'h100);
    check("sim_mem_wdata", bus.ext_wdata_o,      32'h12345678);
    check("sim_if_stall",  32'(bus.if_stall_o),  32'd1);
    check("sim_mem_stall", 32'(bus.mem_stall_o), 32'd1);
    bus.ext_ack_i   = 1'b1;
    bus.ext_rdata_i = 32'hFFFFFFFF;
    step();
    check("sim_mem_ready", 32'(bus.mem_ready_o), 32'd1);
    check("sim_wr_nocap",  bus.mem_rdata_o,      32'd0);
    check("sim_ifr_lo",    32'(bus.if_ready_o),  32'd0);
    bus.ext_ack_i = 1'b0;
    step();
    check("sim_if_grant", 32'(bus.ext_req_o),   32'd1);
    check("sim_if_addr",  bus.ext_addr_o,       32'h44);
    check("sim_if_we",    32'(bus.ext_we_o),    32'd0);
    check("sim_mem_lo",   32'(bus.mem_ready_o), 32'd0);
    bus.mem_req_i   = 1'b0;
    bus.ext_ack_i   = 1'b1;
    bus.ext_rdata_i = 32'h11112222;
    step();
    check("sim_if_ready", 32'(bus.if_ready_o), 32'd1);
    check("sim_if_data",  bus.if_data_o,       32'h11112222);
    exp_if_data   = 32'h11112222;
    bus.ext_ack_i = 1'b0;
    bus.if_req_i  = 1'b0;
    step();
    check("sim_no_dup",    32'(bus.ext_req_o),   32'd0);
    check("sim_mem_quiet", 32'(bus.mem_ready_o), 32'd0);
    idle_inputs();
`endif

    // Variable latency: ack on the 7th wait cycle
    bus.mem_req_i  = 1'b1;
    bus.mem_we_i   = 1'b0;
    bus.mem_addr_i = 32'h200;
    step();
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      check("lat_addr_stable", bus.ext_addr_o,     32'h200);
      check("lat_req_high",    32'(bus.ext_req_o), 32'd1);
      if (bus.mem_ready_o) pulses++;
      if (i == 6) begin
        bus.ext_ack_i   = 1'b1;
        bus.ext_rdata_i = 32'hCAFE0001;
      end
      step();
    end
    for (int j = 0; j < 4; j++) begin
      if (bus.mem_ready_o) pulses++;
      if (j == 0) begin
        check("lat_rdata", bus.mem_rdata_o, 32'hCAFE0001);
        bus.ext_ack_i = 1'b0;
        bus.mem_req_i = 1'b0;
      end
      step();
    end
    check("lat_one_pulse", 32'(pulses),     32'd1);
    check("lat_no_err",    32'(bus.err_o),  32'd0);

    // Watchdog: no ack, abort after 8 wait cycles
    bus.mem_req_i  = 1'b1;
    bus.mem_we_i   = 1'b0;
    bus.mem_addr_i = 32'h300;
    step();
    for (int i = 0; i < 8; i++) begin
      check("to_req_high", 32'(bus.ext_req_o), 32'd1);
      step();
    end
    check("to_req_drop", 32'(bus.ext_req_o),   32'd0);
    check("to_ready",    32'(bus.mem_ready_o), 32'd1);
    check("to_abort",    bus.mem_rdata_o,      32'hDEADBEEF);
    check("to_err",      32'(bus.err_o),       32'd1);
    bus.mem_req_i = 1'b0;
    step();
    check("to_err_sticky", 32'(bus.err_o),       32'd1);
    check("to_one_pulse",  32'(bus.mem_ready_o), 32'd0);

    // Stray ack while IDLE is ignored
    bus.ext_ack_i   = 1'b1;
    bus.ext_rdata_i = 32'h55555555;
    step();
    bus.ext_ack_i = 1'b0;
    check("idle_ack_ifr",  32'(bus.if_ready_o),  32'd0);
    check("idle_ack_memr", 32'(bus.mem_ready_o), 32'd0);
    check("idle_ack_req",  32'(bus.ext_req_o),   32'd0);
    check("idle_ack_data", bus.if_data_o,        exp_if_data);

    // Transaction after a timeout completes normally
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h48;
    step();
    check("post_to_addr", bus.ext_addr_o, 32'h48);
    bus.ext_ack_i   = 1'b1;
    bus.ext_rdata_i = 32'h0BADF00D;
    step();
    check("post_to_ready", 32'(bus.if_ready_o), 32'd1);
    check("post_to_data",  bus.if_data_o,       32'h0BADF00D);
    check("post_to_err",   32'(bus.err_o),      32'd1);
    bus.ext_ack_i = 1'b0;
    bus.if_req_i  = 1'b0;
    step();

    // Both requesters held continuously; record grant order (1 = MEM write)
`ifdef ARB_FAIR_EN
    exp_we = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
    exp_we = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif
    bus.mem_req_i   = 1'b1;
    bus.mem_we_i    = 1'b1;
    bus.mem_addr_i  = 32'h400;
    bus.mem_wdata_i = 32'hA5A5A5A5;
    bus.if_req_i    = 1'b1;
    bus.if_addr_i   = 32'h80;
    bus.ext_rdata_i = 32'h13572468;
    prev_req = 1'b0;
    n_grants = 0;
    for (int cyc = 0; cyc < 200 && n_grants < 10; cyc++) begin
      step();
      if (bus.ext_req_o && !prev_req) begin
        grant_we[n_grants] = bus.ext_we_o;
        n_grants++;
      end
      prev_req      = bus.ext_req_o;
      bus.ext_ack_i = bus.ext_req_o;
    end
    check("arb_grant_count", 32'(n_grants), 32'd10);
    for (int k = 0; k < 10; k++) begin
      if (k < n_grants) check($sformatf("arb_order_%0d", k), 32'(grant_we[k]), 32'(exp_we[k]));
    end
    step();
    bus.ext_ack_i = 1'b0;
    idle_inputs();
    step();
    step();

    // Asynchronous reset in the middle of a MEM transaction
    bus.mem_req_i  = 1'b1;
    bus.mem_we_i   = 1'b0;
    bus.mem_addr_i = 32'h500;
    step();
    check("rstm_granted", 32'(bus.ext_req_o), 32'd1);
    bus.mem_req_i = 1'b0;
    rst_n_i = 1'b0;
    #1;
    check("rstm_req",       32'(bus.ext_req_o),   32'd0);
    check("rstm_mem_ready", 32'(bus.mem_ready_o), 32'd0);
    check("rstm_if_ready",  32'(bus.if_ready_o),  32'd0);
    check("rstm_err",       32'(bus.err_o),       32'd0);
    step();
    rst_n_i = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.mem_ready_o || bus.if_ready_o) pulses++;
      check("rstm_quiet_req", 32'(bus.ext_req_o), 32'd0);
    end
    check("rstm_no_pulse", 32'(pulses), 32'd0);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h60;
    step();
    check("rstm_idle_grant", 32'(bus.ext_req_o), 32'd1);
    check("rstm_idle_addr",  bus.ext_addr_o,     32'h60);
    bus.ext_ack_i   = 1'b1;
    bus.ext_rdata_i = 32'h600D600D;
    step();
    check("rstm_if_ready", 32'(bus.if_ready_o), 32'd1);
    check("rstm_if_data",  bus.if_data_o,       32'h600D600D);
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
